// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/DIV sequencer that owns the HI/LO register pair.
// The control unit pulses Start with the rs/rt operands and stalls while Busy
// is high. The block runs a shift-add multiply or a restoring divide, one bit
// per clock. A final FIX cycle applies the sign correction and writes Hi/Lo,
// and Done pulses for one cycle when the result is available.
//
// Optional feature: define MULDIV_UNSIGNED_EN to make Op[1] select the
// unsigned MULTU/DIVU variants. Without it, Op[1] is ignored and no unsigned
// path is built. Latency is the same in both builds.

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      counter_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               signA_q;
  logic               signB_q;
  logic               signed_q;
  logic               isDiv_q;
  logic               busy_q;
  logic               done_q;
  logic               divZero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               reqSigned;
  logic               reqDiv;
  logic               negA;
  logic               negB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] accMul_d;
  logic [2*WIDTH:0]   divShift;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] accDiv_d;

  logic [2*WIDTH-1:0] fixProduct;
  logic [WIDTH-1:0]   fixQuot;
  logic [WIDTH-1:0]   fixRem;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

`ifndef MULDIV_UNSIGNED_EN
  logic unusedOpBit;
  assign unusedOpBit = Op[1];
`endif

  // Decode the request and take operand magnitudes; 0x80..0 negates to itself,
  // which is exactly the unsigned magnitude we want.
  always_comb begin
    reqSigned = 1'b1;
`ifdef MULDIV_UNSIGNED_EN
    reqSigned = ~Op[1];
`endif
    reqDiv = Op[0];
    negA   = reqSigned & A[WIDTH-1];
    negB   = reqSigned & B[WIDTH-1];
    magA   = negA ? -A : A;
    magB   = negB ? -B : B;
  end

  // One multiply iteration: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  // The add carry lands in the top bit after the shift, so no extra bit is kept.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    accMul_d = {mulSum, acc_q[WIDTH-1:1]};
  end

  // One restoring divide iteration: remainder sits in the upper half and the
  // quotient shifts in at the bottom. The remainder is always below the divisor,
  // so the bit lost on a failed trial is known to be zero.
  always_comb begin
    divShift = {acc_q, 1'b0};
    divTrial = divShift[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    if (divTrial[WIDTH]) begin
      accDiv_d = divShift[2*WIDTH-1:0];
    end else begin
      accDiv_d = {divTrial[WIDTH-1:0], divShift[WIDTH-1:1], 1'b1};
    end
  end

  // Sign correction applied in the FIX cycle: product and quotient follow the
  // XOR of operand signs, and the remainder follows the dividend's sign.
  always_comb begin
    fixProduct = (signed_q & (signA_q ^ signB_q)) ? -acc_q : acc_q;
    fixQuot    = (signed_q & (signA_q ^ signB_q)) ? -acc_q[WIDTH-1:0]
                                                  : acc_q[WIDTH-1:0];
    fixRem     = (signed_q & signA_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                      : acc_q[2*WIDTH-1:WIDTH];
    if (isDiv_q) begin
      hi_d = fixRem;
      lo_d = fixQuot;
    end else begin
      hi_d = fixProduct[2*WIDTH-1:WIDTH];
      lo_d = fixProduct[WIDTH-1:0];
    end
  end

  // Sequencer: accepts Start only in IDLE, iterates WIDTH times, fixes signs,
  // then raises Done for one cycle. Hi/Lo change only in FIX or on reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      signed_q  <= 1'b0;
      isDiv_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            counter_q <= '0;
            divZero_q <= 1'b0;
            signA_q   <= negA;
            signB_q   <= negB;
            signed_q  <= reqSigned;
            isDiv_q   <= reqDiv;
            busy_q    <= 1'b1;
            if (!reqDiv) begin
              opnd_q  <= magA;
              acc_q   <= {{WIDTH{1'b0}}, magB};
              state_q <= MUL;
            end else if (B == '0) begin
              divZero_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              opnd_q  <= magB;
              acc_q   <= {{WIDTH{1'b0}}, magA};
              state_q <= DIV;
            end
          end
        end
        MUL: begin
          acc_q     <= accMul_d;
          counter_q <= counter_q + CW'(1);
          if (counter_q == LastCount) begin
            state_q <= FIX;
          end
        end
        DIV: begin
          acc_q     <= accDiv_d;
          counter_q <= counter_q + CW'(1);
          if (counter_q == LastCount) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divZero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq with hand-computed
// results, handshake timing, divide-by-zero, overflow wrap, ignored Start
// pulses and asynchronous reset abort. Expected values for Op=10/11 depend on
// whether MULDIV_UNSIGNED_EN is defined for the build.

module tb_muldiv_seq;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int asserts  = 0;
  int failures = 0;

  int   doneEdge;
  int   busyCycles;
  int   doneCycles;
  logic dzFirst;

  muldiv_seq #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  // 10 ns clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    asserts++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Launch one operation at the next rising edge (E0), scramble operands after
  // E0, then sample every falling edge until Busy drops. Sample index e is the
  // cycle between edge E(e) and E(e+1). An optional second Start is pulsed so
  // that it is seen at edge E(rePulseEdge).
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input int rePulseEdge,
                               output int dEdge, output int bCycles,
                               output int dCycles, output logic dz0);
    logic finished;
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(posedge Clk);
    #1;
    Start    = 1'b0;
    A        = $urandom;
    B        = $urandom;
    dEdge    = -1;
    bCycles  = 0;
    dCycles  = 0;
    dz0      = 1'b0;
    finished = 1'b0;
    for (int e = 0; e < 100; e++) begin
      @(negedge Clk);
      if (e == 0) dz0 = DivZero;
      if (Busy) bCycles++;
      if (Done) begin
        dCycles++;
        if (dEdge < 0) dEdge = e;
      end
      if (Start) Start = 1'b0;
      if (e == rePulseEdge - 1) begin
        Start = 1'b1;
        Op    = 2'b01;
        A     = 32'h0000_1234;
        B     = 32'h0000_0005;
      end
      if (!Busy) begin
        finished = 1'b1;
        break;
      end
    end
    Start = 1'b0;
    checkOutput({tag, "-completes"}, {63'd0, finished}, 64'd1);
  endtask

  // Global safety net so the bench can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 2'b00;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    $display("[TB] checking reset state");
    checkOutput("rst-busy",    {63'd0, Busy},    64'd0);
    checkOutput("rst-done",    {63'd0, Done},    64'd0);
    checkOutput("rst-divzero", {63'd0, DivZero}, 64'd0);
    checkOutput("rst-hi",      {32'd0, Hi},      64'd0);
    checkOutput("rst-lo",      {32'd0, Lo},      64'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // MULT 7 * -3 = -21, with full handshake timing
    $display("[TB] MULT 7 * -3");
    applyStimulus("mult7", 2'b00, 32'd7, 32'hFFFF_FFFD, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("mult7-doneEdge",   doneEdge,   33);
    checkOutput("mult7-busyCycles", busyCycles, 34);
    checkOutput("mult7-doneCycles", doneCycles, 1);
    checkOutput("mult7-hi", {32'd0, Hi}, 64'hFFFF_FFFF);
    checkOutput("mult7-lo", {32'd0, Lo}, 64'hFFFF_FFEB);
    checkOutput("mult7-divzero", {63'd0, DivZero}, 64'd0);

    // DIV -7 / 2 = -3 rem -1
    $display("[TB] DIV -7 / 2");
    applyStimulus("divneg", 2'b01, 32'hFFFF_FFF9, 32'd2, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("divneg-doneEdge", doneEdge, 33);
    checkOutput("divneg-lo", {32'd0, Lo}, 64'hFFFF_FFFD);
    checkOutput("divneg-hi", {32'd0, Hi}, 64'hFFFF_FFFF);

    // DIV 100 / 7 = 14 rem 2
    applyStimulus("div100", 2'b01, 32'd100, 32'd7, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("div100-lo", {32'd0, Lo}, 64'd14);
    checkOutput("div100-hi", {32'd0, Hi}, 64'd2);

    // Preload 3*5, then divide by zero: Hi/Lo must hold
    $display("[TB] divide by zero");
    applyStimulus("mult35", 2'b00, 32'd3, 32'd5, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("mult35-hi", {32'd0, Hi}, 64'd0);
    checkOutput("mult35-lo", {32'd0, Lo}, 64'd15);
    applyStimulus("divz", 2'b01, 32'd100, 32'd0, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("divz-doneEdge",   doneEdge,   0);
    checkOutput("divz-busyCycles", busyCycles, 1);
    checkOutput("divz-doneCycles", doneCycles, 1);
    checkOutput("divz-flag", {63'd0, DivZero}, 64'd1);
    checkOutput("divz-hi", {32'd0, Hi}, 64'd0);
    checkOutput("divz-lo", {32'd0, Lo}, 64'd15);
    repeat (5) @(negedge Clk);
    checkOutput("divz-sticky", {63'd0, DivZero}, 64'd1);

    // Overflow / wrap cases; DivZero clears on the accepted Start
    $display("[TB] overflow cases");
    applyStimulus("mulmin", 2'b00, 32'h8000_0000, 32'h8000_0000, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("mulmin-dzclear", {63'd0, dzFirst}, 64'd0);
    checkOutput("mulmin-hi", {32'd0, Hi}, 64'h4000_0000);
    checkOutput("mulmin-lo", {32'd0, Lo}, 64'd0);
    applyStimulus("divmin", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("divmin-lo", {32'd0, Lo}, 64'h8000_0000);
    checkOutput("divmin-hi", {32'd0, Hi}, 64'd0);

    // Start re-pulsed at E5 must be ignored
    $display("[TB] Start while busy");
    applyStimulus("repulse", 2'b00, 32'd2, 32'd3, 5,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("repulse-doneEdge", doneEdge, 33);
    checkOutput("repulse-hi", {32'd0, Hi}, 64'd0);
    checkOutput("repulse-lo", {32'd0, Lo}, 64'd6);
    repeat (3) @(negedge Clk);
    checkOutput("repulse-idle", {63'd0, Busy}, 64'd0);

    // Reset asserted mid-operation, just after E10
    $display("[TB] reset abort");
    @(negedge Clk);
    Start = 1'b1;
    Op    = 2'b00;
    A     = 32'd9;
    B     = 32'd9;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("abort-busy", {63'd0, Busy}, 64'd0);
    checkOutput("abort-done", {63'd0, Done}, 64'd0);
    checkOutput("abort-hi",   {32'd0, Hi},   64'd0);
    checkOutput("abort-lo",   {32'd0, Lo},   64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus("afterabort", 2'b00, 32'd4, 32'd5, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("afterabort-doneEdge", doneEdge, 33);
    checkOutput("afterabort-lo", {32'd0, Lo}, 64'd20);
    checkOutput("afterabort-hi", {32'd0, Hi}, 64'd0);

    // Op[1] variants
    $display("[TB] Op[1] variants");
    applyStimulus("multu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("multu-doneEdge", doneEdge, 33);
`ifdef MULDIV_UNSIGNED_EN
    checkOutput("multu-hi", {32'd0, Hi}, 64'hFFFF_FFFE);
    checkOutput("multu-lo", {32'd0, Lo}, 64'h0000_0001);
`else
    checkOutput("multu-hi", {32'd0, Hi}, 64'h0000_0000);
    checkOutput("multu-lo", {32'd0, Lo}, 64'h0000_0001);
`endif
    applyStimulus("divu", 2'b11, 32'hFFFF_FFF9, 32'd2, -1,
                  doneEdge, busyCycles, doneCycles, dzFirst);
    checkOutput("divu-busyCycles", busyCycles, 34);
`ifdef MULDIV_UNSIGNED_EN
    checkOutput("divu-lo", {32'd0, Lo}, 64'h7FFF_FFFC);
    checkOutput("divu-hi", {32'd0, Hi}, 64'h0000_0001);
`else
    checkOutput("divu-lo", {32'd0, Lo}, 64'hFFFF_FFFD);
    checkOutput("divu-hi", {32'd0, Hi}, 64'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
